pulse_stretcher: RTL and testbench
==================================

PULSE_STRETCHER -- requirements
Module: pulse_stretcher

Interface
REQ-001 The block SHALL have parameter HIGH_CYCLES, default 16, which is the number of clock cycles out is held high per trigger; legal range is 1 or more.
REQ-002 The block SHALL have parameter GAP_CYCLES, default 4, which is the minimum number of cycles out stays low between two stretched pulses; legal range is 1 or more.
REQ-003 The block SHALL have parameter RETRIGGER, default 0: 0 queues a trigger that arrives during HIGH, 1 reloads the HIGH count.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have port in, input, 1 bit: trigger request, sampled every rising edge; each cycle it is high counts as one trigger.
REQ-007 The block SHALL have port out, output, 1 bit: the stretched level, registered.
REQ-008 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-009 The block SHALL have port done, output, 1 bit: a one-cycle pulse in the first cycle after out falls, registered.
REQ-010 The block SHALL have port drop_cnt, output, 8 bits: a saturating count of discarded triggers.
REQ-011 Counter widths SHALL be $clog2(max(HIGH_CYCLES, GAP_CYCLES)+1); illegal parameter values SHALL fail elaboration.

Function
REQ-012 The state machine SHALL have exactly three states, IDLE, HIGH and GAP, plus a single-bit pending flag.
REQ-013 In IDLE, in=1 at edge k SHALL cause the move to HIGH, with out=1 from edge k onward (one-edge latency) and the HIGH count loaded.
REQ-014 In HIGH, out SHALL stay 1 for exactly HIGH_CYCLES cycles, measured from the last load.
REQ-015 At HIGH expiry, the block SHALL set out=0 and done=1 for one cycle, enter GAP, and load the GAP count; the done cycle counts as the first GAP cycle.
REQ-016 In GAP, out SHALL stay 0 for exactly GAP_CYCLES cycles.
REQ-017 At GAP expiry with pending=1, the block SHALL enter HIGH, set out=1, and clear pending; with pending=0 it SHALL enter IDLE.
REQ-018 With RETRIGGER=1, in=1 during HIGH SHALL reload the HIGH count, so out remains high HIGH_CYCLES cycles past that edge, with no done and no gap.
REQ-019 With RETRIGGER=0, in=1 during HIGH SHALL set pending if it is clear, and otherwise increment drop_cnt.
REQ-020 In GAP, in=1 SHALL set pending if it is clear, and otherwise increment drop_cnt; this applies for either RETRIGGER value.
REQ-021 Simultaneous events:
- in=1 on the last HIGH cycle with RETRIGGER=1 SHALL reload, with no done.
- in=1 on the last HIGH cycle with RETRIGGER=0 SHALL behave as REQ-019.
- in=1 on the last GAP cycle with pending=0 SHALL set pending, which launches HIGH that same edge.
- in=1 on the last GAP cycle with pending=1 SHALL be dropped, with the launch proceeding.
REQ-022 drop_cnt SHALL saturate at 255 and never wrap; it clears only on reset.
REQ-023 done SHALL never be asserted in the same cycle as out=1.
REQ-024 A level held high on in SHALL produce repeated stretched pulses separated by GAP_CYCLES low cycles; surplus cycles are counted as drops.

Reset
REQ-025 rst_n=0 SHALL immediately and asynchronously force:
- state=IDLE
- out=0, busy=0, done=0
- pending=0
- drop_cnt=0
- both counters=0
REQ-026 Reset asserted mid-HIGH or mid-GAP SHALL abandon the operation; after release, no residual pulse and no done SHALL appear.
REQ-027 Triggers presented while rst_n=0 SHALL be ignored, and the first edge after release SHALL sample in normally.

Verification (defaults HIGH_CYCLES=16, GAP_CYCLES=4)
REQ-028 Single 1-cycle in pulse from IDLE -> out high for 16 cycles starting the next cycle, then done for 1 cycle, busy for 20 cycles total, drop_cnt=0.
REQ-029 RETRIGGER=0, pulses at cycles 0 and 5 -> out 16 high, 4 low, 16 high; two done pulses; drop_cnt=0.
REQ-030 RETRIGGER=0, pulses at cycles 0, 3, 7 and 12 -> second pulse queued, drop_cnt=2.
REQ-031 RETRIGGER=1, pulses at cycles 0 and 10 -> out continuously high for 26 cycles, exactly one done.
REQ-032 rst_n low for 1 cycle at cycle 8 of HIGH, with a pulse pending -> out, busy and done go 0 at once; after release the block stays in IDLE with no output until a new in.
REQ-033 in held high for 600 cycles -> out alternates 16 high / 4 low; drop_cnt saturates at 255 and holds.

Source files
------------

// File: rtl/pulse_stretcher.sv
// pulse_stretcher
// Turns each single-cycle trigger on `in` into a stretched high level on `out`.
// Each stretched pulse lasts HIGH_CYCLES cycles and is followed by at least
// GAP_CYCLES low cycles. One trigger arriving while a pulse is active can be
// held in a pending flag and launched later. Triggers beyond that are counted
// in a saturating drop counter. With RETRIGGER set, a trigger during HIGH
// extends the current pulse instead of queueing a new one.

module pulse_stretcher #(
    parameter int HIGH_CYCLES = 16,
    parameter int GAP_CYCLES  = 4,
    parameter int RETRIGGER   = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in,
    output logic       out,
    output logic       busy,
    output logic       done,
    output logic [7:0] drop_cnt
);

    // Parameter legality: any illegal value stops elaboration.
    if (HIGH_CYCLES < 1) begin : g_bad_high_cycles
        $error("pulse_stretcher: HIGH_CYCLES must be 1 or more");
    end
    if (GAP_CYCLES < 1) begin : g_bad_gap_cycles
        $error("pulse_stretcher: GAP_CYCLES must be 1 or more");
    end
    if ((RETRIGGER != 0) && (RETRIGGER != 1)) begin : g_bad_retrigger
        $error("pulse_stretcher: RETRIGGER must be 0 or 1");
    end

    localparam int MAX_CYCLES = (HIGH_CYCLES > GAP_CYCLES) ? HIGH_CYCLES : GAP_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    // A counter loaded with N-1 reaches zero on the N-th cycle of its phase.
    localparam logic [CW-1:0] HIGH_LOAD = CW'(HIGH_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam bit            RETRIG_EN = (RETRIGGER != 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_HIGH = 2'b01,
        ST_GAP  = 2'b10
    } state_t;

    state_t          state_r,    state_s;
    logic [CW-1:0]   high_cnt_r, high_cnt_s;
    logic [CW-1:0]   gap_cnt_r,  gap_cnt_s;
    logic            pending_r,  pending_s;
    logic            out_r,      out_s;
    logic            busy_r,     busy_s;
    logic            done_r,     done_s;
    logic [7:0]      drop_cnt_r, drop_cnt_s;
    logic            drop_s;
    logic            pend_eff_s;

    // Saturating increment so the drop counter sticks at its maximum.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        if (v == 8'hFF) begin
            return 8'hFF;
        end else begin
            return v + 8'd1;
        end
    endfunction

    // Next-state, counter, pending-flag and output decode.
    always_comb begin
        state_s    = state_r;
        high_cnt_s = high_cnt_r;
        gap_cnt_s  = gap_cnt_r;
        pending_s  = pending_r;
        out_s      = 1'b0;
        done_s     = 1'b0;
        drop_s     = 1'b0;
        pend_eff_s = pending_r;

        case (state_r)
            ST_IDLE: begin
                if (in) begin
                    state_s    = ST_HIGH;
                    high_cnt_s = HIGH_LOAD;
                    out_s      = 1'b1;
                end else begin
                    out_s      = 1'b0;
                end
            end

            ST_HIGH: begin
                if (in && RETRIG_EN) begin
                    // Reload: the pulse now ends HIGH_CYCLES cycles from here.
                    high_cnt_s = HIGH_LOAD;
                    out_s      = 1'b1;
                end else begin
                    if (in) begin
                        if (pending_r) begin
                            drop_s = 1'b1;
                        end else begin
                            pending_s = 1'b1;
                        end
                    end else begin
                        pending_s = pending_r;
                    end

                    if (high_cnt_r == CNT_ZERO) begin
                        // The done cycle is the first cycle of the gap.
                        state_s    = ST_GAP;
                        gap_cnt_s  = GAP_LOAD;
                        high_cnt_s = CNT_ZERO;
                        out_s      = 1'b0;
                        done_s     = 1'b1;
                    end else begin
                        high_cnt_s = high_cnt_r - CNT_ONE;
                        out_s      = 1'b1;
                    end
                end
            end

            ST_GAP: begin
                // A trigger on the final gap cycle may still fill an empty
                // pending slot and launch immediately.
                if (in) begin
                    if (pending_r) begin
                        drop_s = 1'b1;
                    end else begin
                        pend_eff_s = 1'b1;
                    end
                end else begin
                    pend_eff_s = pending_r;
                end

                if (gap_cnt_r == CNT_ZERO) begin
                    pending_s = 1'b0;
                    if (pend_eff_s) begin
                        state_s    = ST_HIGH;
                        high_cnt_s = HIGH_LOAD;
                        out_s      = 1'b1;
                    end else begin
                        state_s    = ST_IDLE;
                        out_s      = 1'b0;
                    end
                end else begin
                    gap_cnt_s = gap_cnt_r - CNT_ONE;
                    pending_s = pend_eff_s;
                end
            end

            default: begin
                state_s    = ST_IDLE;
                high_cnt_s = CNT_ZERO;
                gap_cnt_s  = CNT_ZERO;
                pending_s  = 1'b0;
            end
        endcase

        busy_s = (state_s != ST_IDLE);

        if (drop_s) begin
            drop_cnt_s = sat_inc8(drop_cnt_r);
        end else begin
            drop_cnt_s = drop_cnt_r;
        end
    end

    // State, counters and registered outputs; reset abandons any activity.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            high_cnt_r <= CNT_ZERO;
            gap_cnt_r  <= CNT_ZERO;
            pending_r  <= 1'b0;
            out_r      <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            drop_cnt_r <= 8'd0;
        end else begin
            state_r    <= state_s;
            high_cnt_r <= high_cnt_s;
            gap_cnt_r  <= gap_cnt_s;
            pending_r  <= pending_s;
            out_r      <= out_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
            drop_cnt_r <= drop_cnt_s;
        end
    end

    assign out      = out_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign drop_cnt = drop_cnt_r;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Testbench for pulse_stretcher: a queueing instance and a retriggering
// instance share one trigger input. An abstract model computes the expected
// outputs from remaining-high / remaining-gap cycle counts. Literal
// expectations on pulse lengths, done counts and drop counts pin that model.

module tb_pulse_stretcher;

    localparam int HC = 16;
    localparam int GC = 4;

    logic       clk;
    logic       rst_n;
    logic       in;
    logic       out_q, busy_q, done_q;
    logic [7:0] drop_q;
    logic       out_r, busy_r, done_r;
    logic [7:0] drop_r;

    int passed;
    int total;
    bit check_en;

    pulse_stretcher #(.HIGH_CYCLES(HC), .GAP_CYCLES(GC), .RETRIGGER(0)) dut_q (
        .clk(clk), .rst_n(rst_n), .in(in),
        .out(out_q), .busy(busy_q), .done(done_q), .drop_cnt(drop_q)
    );

    pulse_stretcher #(.HIGH_CYCLES(HC), .GAP_CYCLES(GC), .RETRIGGER(1)) dut_r (
        .clk(clk), .rst_n(rst_n), .in(in),
        .out(out_r), .busy(busy_r), .done(done_r), .drop_cnt(drop_r)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- abstract model ----------------
    typedef struct packed {
        int hi;     // high cycles still to show, counting the current one
        int gap;    // low gap cycles still to show, counting the current one
        bit pend;
        bit done;
        int drops;
    } model_t;

    model_t mq = '0;
    model_t mr = '0;

    function automatic int sat_add(int d);
        return (d < 255) ? d + 1 : 255;
    endfunction

    function automatic model_t model_next(model_t m, logic x, bit retrig);
        model_t n = m;
        n.done = 1'b0;
        if (m.hi > 0) begin
            if (x && retrig) begin
                n.hi = HC;
            end else begin
                if (x) begin
                    if (m.pend) n.drops = sat_add(m.drops);
                    else        n.pend  = 1'b1;
                end
                n.hi = m.hi - 1;
                if (n.hi == 0) begin
                    n.gap  = GC;
                    n.done = 1'b1;
                end
            end
        end else if (m.gap > 0) begin
            if (x) begin
                if (m.pend) n.drops = sat_add(m.drops);
                else        n.pend  = 1'b1;
            end
            n.gap = m.gap - 1;
            if (n.gap == 0 && n.pend) begin
                n.pend = 1'b0;
                n.hi   = HC;
            end
        end else if (x) begin
            n.hi = HC;
        end
        return n;
    endfunction

    // Model advances on the same edge as the DUT and clears on reset.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq <= '0;
            mr <= '0;
        end else begin
            mq <= model_next(mq, in, 1'b0);
            mr <= model_next(mr, in, 1'b1);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // ---------------- run statistics ----------------
    int hi_n[2], done_n[2], busy_n[2], run[2], maxrun[2];

    task automatic clear_stats();
        for (int i = 0; i < 2; i++) begin
            hi_n[i] = 0; done_n[i] = 0; busy_n[i] = 0; run[i] = 0; maxrun[i] = 0;
        end
    endtask

    task automatic note(input int i, input logic o, input logic b, input logic d);
        if (o) begin
            hi_n[i]++;
            run[i]++;
            if (run[i] > maxrun[i]) maxrun[i] = run[i];
        end else begin
            run[i] = 0;
        end
        if (b) busy_n[i]++;
        if (d) done_n[i]++;
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (check_en) begin
            check("q.out",  int'(out_q),  int'(mq.hi > 0));
            check("q.busy", int'(busy_q), int'((mq.hi > 0) || (mq.gap > 0)));
            check("q.done", int'(done_q), int'(mq.done));
            check("q.drop", int'(drop_q), mq.drops);
            check("r.out",  int'(out_r),  int'(mr.hi > 0));
            check("r.busy", int'(busy_r), int'((mr.hi > 0) || (mr.gap > 0)));
            check("r.done", int'(done_r), int'(mr.done));
            check("r.drop", int'(drop_r), mr.drops);
            if (done_q && out_q) check("q.done_with_out", 1, 0);
            if (done_r && out_r) check("r.done_with_out", 1, 0);
            note(0, out_q, busy_q, done_q);
            note(1, out_r, busy_r, done_r);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_reset();
        @(negedge clk); #1;
        in    = 1'b0;
        rst_n = 1'b0;
        @(negedge clk); #1;
        rst_n = 1'b1;
        clear_stats();
    endtask

    // Bit i of pat is the trigger value for cycle i; followed by idle cycles.
    task automatic play(input logic [63:0] pat, input int n);
        logic [63:0] p;
        p = pat;
        for (int i = 0; i < n; i++) begin
            @(negedge clk); #1;
            in = (i < 64) ? p[i] : 1'b0;
        end
        @(negedge clk); #1;
        in = 1'b0;
    endtask

    initial begin
        passed   = 0;
        total    = 0;
        check_en = 1'b0;
        in       = 1'b0;
        rst_n    = 1'b0;
        clear_stats();
        repeat (2) @(negedge clk);
        #1;
        rst_n    = 1'b1;
        check_en = 1'b1;
        #1;
        check("reset.out",  int'(out_q),  0);
        check("reset.busy", int'(busy_q), 0);
        check("reset.done", int'(done_q), 0);
        check("reset.drop", int'(drop_q), 0);

        // Single pulse from idle.
        do_reset();
        play(64'h1, 30);
        #1;
        check("s1.q.high",  hi_n[0],   16);
        check("s1.q.busy",  busy_n[0], 20);
        check("s1.q.done",  done_n[0], 1);
        check("s1.q.drop",  int'(drop_q), 0);
        check("s1.r.high",  hi_n[1],   16);
        check("s1.model.drop", mq.drops, 0);

        // Pulses at cycles 0 and 5.
        do_reset();
        play(64'h21, 50);
        #1;
        check("s2.q.high",   hi_n[0],   32);
        check("s2.q.maxrun", maxrun[0], 16);
        check("s2.q.done",   done_n[0], 2);
        check("s2.q.drop",   int'(drop_q), 0);
        check("s2.r.maxrun", maxrun[1], 21);
        check("s2.r.done",   done_n[1], 1);

        // Pulses at cycles 0, 3, 7 and 12.
        do_reset();
        play(64'h1089, 50);
        #1;
        check("s3.q.drop",   int'(drop_q), 2);
        check("s3.model.drop", mq.drops, 2);
        check("s3.q.high",   hi_n[0],   32);
        check("s3.q.done",   done_n[0], 2);
        check("s3.r.maxrun", maxrun[1], 28);
        check("s3.r.drop",   int'(drop_r), 0);

        // Pulses at cycles 0 and 10.
        do_reset();
        play(64'h401, 50);
        #1;
        check("s4.r.maxrun", maxrun[1], 26);
        check("s4.r.high",   hi_n[1],   26);
        check("s4.r.done",   done_n[1], 1);
        check("s4.q.high",   hi_n[0],   32);
        check("s4.q.done",   done_n[0], 2);

        // Reset in the middle of HIGH with a trigger pending.
        do_reset();
        play(64'h9, 7);
        @(negedge clk); #1;
        rst_n = 1'b0;
        in    = 1'b1;
        #1;
        check("s5.q.out_now",  int'(out_q),  0);
        check("s5.q.busy_now", int'(busy_q), 0);
        check("s5.q.done_now", int'(done_q), 0);
        check("s5.r.out_now",  int'(out_r),  0);
        @(negedge clk); #1;
        in    = 1'b0;
        rst_n = 1'b1;
        clear_stats();
        play(64'h0, 30);
        #1;
        check("s5.q.high", hi_n[0],   0);
        check("s5.q.busy", busy_n[0], 0);
        check("s5.q.done", done_n[0], 0);
        check("s5.r.high", hi_n[1],   0);

        // Trigger level present at release is sampled by the first edge.
        do_reset();
        @(negedge clk); #1;
        rst_n = 1'b0;
        in    = 1'b1;
        @(negedge clk); #1;
        rst_n = 1'b1;
        clear_stats();
        @(negedge clk); #1;
        in = 1'b0;
        play(64'h0, 25);
        #1;
        check("s6.q.high", hi_n[0], 16);

        // Level held high for 600 cycles.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            @(negedge clk); #1;
            in = 1'b1;
        end
        @(negedge clk); #1;
        in = 1'b0;
        #1;
        check("s7.q.drop",   int'(drop_q), 255);
        check("s7.model.drop", mq.drops, 255);
        check("s7.q.maxrun", maxrun[0], 16);
        check("s7.r.drop",   int'(drop_r), 0);
        play(64'h0, 40);
        #1;
        check("s7.q.drop_hold", int'(drop_q), 255);

        check_en = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
